// File: rtl/trigger_pkg.sv
// Shared types and helpers for trigger-ring sequencers: FSM state encoding,
// default ring size and position-index width.
package trigger_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_STOPPING = 2'd2
   } state_e;

   localparam int RING_N_DEFAULT = 8;

   // Width of a position index for an n-entry ring (never below one bit).
   function automatic int pos_width(input int n);
      return (n < 3) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/trigger_edge.sv
// Single-bit rising-edge detector: o_rise is combinational from i_sig and the
// registered previous sample, so a held-high input yields one pulse.
module trigger_edge (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_sig,
   output logic o_rise
);

   logic last_q;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) last_q <= 1'b0;
      else         last_q <= i_sig;
   end

   assign o_rise = i_sig & ~last_q;

endmodule

// File: rtl/trigger_ring_seq.sv
// One-hot trigger ring sequencer with start/stop run control and dc-style homing.
// Optional ring integrity checker is built when TRIGGER_RING_CHECK_EN is defined.
module trigger_ring_seq
   import trigger_pkg::*;
#(
   parameter  int N    = RING_N_DEFAULT,
   parameter  int HOME = 0,
   localparam int PW   = pos_width(N)
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_advance,
   input  logic          i_advance_gate,
   input  logic          i_dc_reset_n,
   input  logic          i_start,
   input  logic          i_stop,
   output logic [N-1:0]  o_ring,
   output logic [N-1:0]  o_nring,
   output logic [PW-1:0] o_pos,
   output logic          o_running,
   output logic          o_cycle_end,
   output logic          o_ring_err
);

   localparam logic [N-1:0]  RING_ONE  = N'(1);
   localparam logic [N-1:0]  HOME_RING = RING_ONE << HOME;
   localparam logic [PW-1:0] HOME_POS  = PW'(HOME);
   localparam logic [PW-1:0] LAST_POS  = PW'(N - 1);

   state_e        state_q;
   logic [N-1:0]  ring_q;
   logic [PW-1:0] pos_q;
   logic          cycle_end_q;

   logic          adv;
   logic          step;
   logic [PW-1:0] pos_d;
   logic [N-1:0]  ring_d;
   logic          lands_home;

   trigger_edge u_adv_edge (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_sig   (i_advance),
      .o_rise  (adv)
   );

   assign step       = adv & i_advance_gate & (state_q != ST_IDLE);
   assign pos_d      = (pos_q == LAST_POS) ? '0 : pos_q + PW'(1);
   assign ring_d     = {ring_q[N-2:0], ring_q[N-1]};
   assign lands_home = step & (pos_d == HOME_POS);

`ifdef TRIGGER_RING_CHECK_EN
   logic ring_err_q;
   logic ring_bad;

   // A single comparison covers both "exactly one-hot" and "o_pos agrees".
   assign ring_bad = (ring_q != (RING_ONE << pos_q));
`endif

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q     <= ST_IDLE;
         ring_q      <= HOME_RING;
         pos_q       <= HOME_POS;
         cycle_end_q <= 1'b0;
`ifdef TRIGGER_RING_CHECK_EN
         ring_err_q  <= 1'b0;
`endif
      end else if (!i_dc_reset_n) begin
         state_q     <= ST_IDLE;
         ring_q      <= HOME_RING;
         pos_q       <= HOME_POS;
         cycle_end_q <= 1'b0;
`ifdef TRIGGER_RING_CHECK_EN
      end else if (ring_bad) begin
         ring_err_q  <= 1'b1;
         state_q     <= ST_IDLE;
         ring_q      <= HOME_RING;
         pos_q       <= HOME_POS;
         cycle_end_q <= 1'b0;
`endif
      end else begin
         cycle_end_q <= lands_home;
         if (step) begin
            ring_q <= ring_d;
            pos_q  <= pos_d;
         end
         case (state_q)
            ST_IDLE: begin
               ring_q <= HOME_RING;
               pos_q  <= HOME_POS;
               if (i_start && !i_stop) state_q <= ST_RUN;
            end
            ST_RUN: begin
               if (i_stop) state_q <= lands_home ? ST_IDLE : ST_STOPPING;
            end
            ST_STOPPING: begin
               // Already parked at home with nothing pending: drop out quietly.
               if (lands_home || (!step && pos_q == HOME_POS)) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign o_ring      = ring_q;
   assign o_nring     = ~ring_q;
   assign o_pos       = pos_q;
   assign o_running   = (state_q == ST_RUN) || (state_q == ST_STOPPING);
   assign o_cycle_end = cycle_end_q;
`ifdef TRIGGER_RING_CHECK_EN
   assign o_ring_err  = ring_err_q;
`else
   assign o_ring_err  = 1'b0;
`endif

endmodule
